// File: rtl/pmod_ble_router.sv
// pmod_ble_router: frame-safe source mux onto the RN4871 RX pin, TX fan-out and reset pulser.
// Optional feature macro: PMOD_BLE_BREAK_DET_EN adds o_break (long-low detector on the TX line).
module pmod_ble_router #(
    parameter int unsigned N_SRC        = 2,
    parameter int unsigned N_SINK       = 3,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned IDLE_BITS    = 11,
    parameter int unsigned RST_CYCLES   = 100000,
    parameter int unsigned SEL_W        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SRC-1:0]  i_src_rx,
    input  logic [SEL_W-1:0]  i_sel,
    input  logic              i_pmod_txd,
    input  logic              i_bt_rst_req,
    output logic              o_pmod_rxd,
    output logic [N_SINK-1:0] o_sink_tx,
    output logic              o_pmod_rstn,
    output logic [SEL_W-1:0]  o_active_sel,
    output logic              o_switch_pending
`ifdef PMOD_BLE_BREAK_DET_EN
    ,
    output logic              o_break
`endif
);
    localparam int unsigned IDLE_MAX = IDLE_BITS * CLKS_PER_BIT;
    localparam int unsigned IDLE_W   = $clog2(IDLE_MAX + 1);
    localparam int unsigned RST_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_FULL = IDLE_W'(IDLE_MAX);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_MAX - 1);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);

    typedef enum logic {StRoute, StPending} sw_state_e;
    typedef enum logic {StPulse, StRun} rst_state_e;

    logic [N_SRC-1:0]  src_s1_q, src_s2_q;
    logic              txd_s1_q, txd_s2_q;
    sw_state_e         sw_state_q, sw_state_d;
    logic [SEL_W-1:0]  active_sel_q, active_sel_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    rst_state_e        rst_state_q, rst_state_d;
    logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic              rxd_q, rxd_d;
    logic              active_bit, sel_valid, idle_full, commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_s1_q     <= '1;
            src_s2_q     <= '1;
            txd_s1_q     <= 1'b1;
            txd_s2_q     <= 1'b1;
            sw_state_q   <= StRoute;
            active_sel_q <= '0;
            idle_q       <= '0;
            rst_state_q  <= StPulse;
            rst_cnt_q    <= '0;
            rxd_q        <= 1'b1;
        end else begin
            src_s1_q     <= i_src_rx;
            src_s2_q     <= src_s1_q;
            txd_s1_q     <= i_pmod_txd;
            txd_s2_q     <= txd_s1_q;
            sw_state_q   <= sw_state_d;
            active_sel_q <= active_sel_d;
            idle_q       <= idle_d;
            rst_state_q  <= rst_state_d;
            rst_cnt_q    <= rst_cnt_d;
            rxd_q        <= rxd_d;
        end
    end

    // Commit on the edge where the idle run reaches IDLE_MAX cycles, so a frame is never cut.
    always_comb begin
        active_bit   = src_s2_q[active_sel_q];
        sel_valid    = 32'(i_sel) < N_SRC;
        idle_full    = active_bit && (idle_q >= IDLE_LAST);
        sw_state_d   = sw_state_q;
        active_sel_d = active_sel_q;
        commit       = 1'b0;
        case (sw_state_q)
            StRoute: begin
                if (sel_valid && (i_sel != active_sel_q)) sw_state_d = StPending;
            end
            StPending: begin
                if (!sel_valid || (i_sel == active_sel_q)) begin
                    sw_state_d = StRoute;
                end else if (idle_full) begin
                    commit       = 1'b1;
                    active_sel_d = i_sel;
                    sw_state_d   = StRoute;
                end
            end
            default: sw_state_d = StRoute;
        endcase

        idle_d = idle_q;
        if (commit || !active_bit) begin
            idle_d = '0;
        end else if (idle_q != IDLE_FULL) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_comb begin
        rst_state_d = rst_state_q;
        rst_cnt_d   = rst_cnt_q;
        case (rst_state_q)
            StPulse: begin
                if (i_bt_rst_req) begin
                    rst_cnt_d = '0;
                end else if (rst_cnt_q == RST_LAST) begin
                    rst_state_d = StRun;
                    rst_cnt_d   = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (i_bt_rst_req) begin
                    rst_state_d = StPulse;
                    rst_cnt_d   = '0;
                end
            end
            default: rst_state_d = StPulse;
        endcase
        // Gate on the next state so the RX pin is held high exactly while the pulse is active.
        rxd_d = (rst_state_d == StPulse) ? 1'b1 : active_bit;
    end

    assign o_pmod_rxd       = rxd_q;
    assign o_sink_tx        = {N_SINK{txd_s2_q}};
    assign o_pmod_rstn      = (rst_state_q == StRun);
    assign o_active_sel     = active_sel_q;
    assign o_switch_pending = (sw_state_q == StPending);

`ifdef PMOD_BLE_BREAK_DET_EN
    localparam int unsigned BRK_MAX = 20 * CLKS_PER_BIT;
    localparam int unsigned BRK_W   = $clog2(BRK_MAX + 1);
    localparam logic [BRK_W-1:0] BRK_FULL = BRK_W'(BRK_MAX);
    localparam logic [BRK_W-1:0] BRK_LAST = BRK_W'(BRK_MAX - 1);

    logic [BRK_W-1:0] brk_cnt_q;
    logic             brk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brk_cnt_q <= '0;
            brk_q     <= 1'b0;
        end else if (txd_s2_q) begin
            brk_cnt_q <= '0;
            brk_q     <= 1'b0;
        end else begin
            if (brk_cnt_q != BRK_FULL) brk_cnt_q <= brk_cnt_q + 1'b1;
            if (brk_cnt_q == BRK_LAST) brk_q <= 1'b1;
        end
    end

    assign o_break = brk_q;
`else
    // Break detector not built.
`endif
endmodule

// File: tb/tb_pmod_ble_router.sv
// Directed bench for pmod_ble_router: per-cycle vector table plus hand-written switch/reset sequences.
module tb_pmod_ble_router;
    localparam int unsigned N_SRC      = 3;
    localparam int unsigned N_SINK     = 3;
    localparam int unsigned CPB        = 4;
    localparam int unsigned IDLE_BITS  = 11;
    localparam int unsigned RST_CYCLES = 8;
    localparam int unsigned SEL_W      = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_SRC-1:0]  src_rx;
    logic [SEL_W-1:0]  sel;
    logic              pmod_txd;
    logic              bt_rst_req;
    logic              pmod_rxd;
    logic [N_SINK-1:0] sink_tx;
    logic              pmod_rstn;
    logic [SEL_W-1:0]  active_sel;
    logic              switch_pending;
`ifdef PMOD_BLE_BREAK_DET_EN
    logic              brk;
`endif

    pmod_ble_router #(
        .N_SRC       (N_SRC),
        .N_SINK      (N_SINK),
        .CLKS_PER_BIT(CPB),
        .IDLE_BITS   (IDLE_BITS),
        .RST_CYCLES  (RST_CYCLES)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_src_rx        (src_rx),
        .i_sel           (sel),
        .i_pmod_txd      (pmod_txd),
        .i_bt_rst_req    (bt_rst_req),
        .o_pmod_rxd      (pmod_rxd),
        .o_sink_tx       (sink_tx),
        .o_pmod_rstn     (pmod_rstn),
        .o_active_sel    (active_sel),
        .o_switch_pending(switch_pending)
`ifdef PMOD_BLE_BREAK_DET_EN
        ,
        .o_break         (brk)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] src;
        logic       txd;
        logic [1:0] sel;
        logic       req;
        logic       rstn;
        logic       rxd;
        logic [1:0] act;
        logic       pend;
        logic [2:0] sink;
    } vec_t;

    vec_t vecs [20];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       d1, d2;
        logic [9:0] frame;
        int         t_c;

        // Reset pulse with source 0 held low: RX pin must stay high.
        for (int i = 0; i < 7; i++) vecs[i] = '{3'b110, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 3'b111};
        vecs[7]  = '{3'b110, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 3'b111};
        // TX fan-out latency and 3-cycle RX latency.
        vecs[8]  = '{3'b111, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 3'b111};
        vecs[9]  = '{3'b111, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000};
        vecs[10] = '{3'b111, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 3'b000};
        vecs[11] = '{3'b111, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 3'b000};
        vecs[12] = '{3'b111, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 3'b111};
        // Out-of-range select is ignored.
        for (int i = 13; i < 16; i++) vecs[i] = '{3'b111, 1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 3'b111};
        vecs[16] = '{3'b111, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 3'b111};
        // Non-selected source activity does not reach the RX pin.
        vecs[17] = '{3'b101, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 3'b111};
        vecs[18] = '{3'b101, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 3'b111};
        vecs[19] = '{3'b111, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 3'b111};

        rst_n = 1'b1; src_rx = 3'b110; sel = 2'd0; pmod_txd = 1'b1; bt_rst_req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_rxd", 32'(pmod_rxd), 32'd1);
        chk("rst_sink", 32'(sink_tx), 32'h7);
        chk("rst_rstn", 32'(pmod_rstn), 32'd0);
        chk("rst_active", 32'(active_sel), 32'd0);
        chk("rst_pending", 32'(switch_pending), 32'd0);
`ifdef PMOD_BLE_BREAK_DET_EN
        chk("rst_break", 32'(brk), 32'd0);
`endif
        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            src_rx = vecs[i].src; pmod_txd = vecs[i].txd; sel = vecs[i].sel; bt_rst_req = vecs[i].req;
            tick();
            chk($sformatf("vec%0d_rstn", i), 32'(pmod_rstn), 32'(vecs[i].rstn));
            chk($sformatf("vec%0d_rxd", i), 32'(pmod_rxd), 32'(vecs[i].rxd));
            chk($sformatf("vec%0d_active", i), 32'(active_sel), 32'(vecs[i].act));
            chk($sformatf("vec%0d_pending", i), 32'(switch_pending), 32'(vecs[i].pend));
            chk($sformatf("vec%0d_sink", i), 32'(sink_tx), 32'(vecs[i].sink));
        end

        // 0x55 on source 0, switch to source 1 requested mid-frame.
        frame = 10'b1010101010;
        d1 = 1'b1; d2 = 1'b1;
        for (int b = 0; b < 9; b++) begin
            for (int c = 0; c < int'(CPB); c++) begin
                if (b == 5 && c == 0) sel = 2'd1;
                src_rx[0] = frame[b];
                tick();
                chk("frame_rxd", 32'(pmod_rxd), 32'(d2));
                d2 = d1; d1 = frame[b];
                if (b == 5 && c == 0) chk("frame_pending", 32'(switch_pending), 32'd1);
            end
        end
        src_rx[0] = 1'b1;
        t_c = 0;
        for (int t = 1; t <= 80; t++) begin
            tick();
            chk("stop_rxd", 32'(pmod_rxd), 32'(d2));
            d2 = d1; d1 = 1'b1;
            if (active_sel == 2'd1) begin
                t_c = t;
                break;
            end
        end
        // Stop bit shows at the synchronizer output on tick 2; commit 44 edges later.
        chk("switch_latency", 32'(t_c), 32'd46);
        chk("switch_done_pending", 32'(switch_pending), 32'd0);

        sel = 2'd0;
        t_c = 0;
        for (int t = 1; t <= 100; t++) begin
            tick();
            if (active_sel == 2'd0) begin
                t_c = t;
                break;
            end
        end
        chk("back_to_0_latency", 32'(t_c), 32'd44);

        // 0 -> 1 -> 0 while source 0 is idle-saturated.
        repeat (50) tick();
        sel = 2'd1;
        tick();
        chk("sat_pending", 32'(switch_pending), 32'd1);
        chk("sat_active_before", 32'(active_sel), 32'd0);
        tick();
        chk("sat_commit", 32'(active_sel), 32'd1);
        chk("sat_commit_pending", 32'(switch_pending), 32'd0);
        sel = 2'd0;
        t_c = 0;
        for (int t = 1; t <= 100; t++) begin
            tick();
            if (t == 1) chk("return_pending", 32'(switch_pending), 32'd1);
            if (active_sel == 2'd0) begin
                t_c = t;
                break;
            end
        end
        chk("return_latency", 32'(t_c), 32'd44);

        // Reset re-pulse, restarted at count 5; source 0 low to prove RX is forced high.
        chk("run_rstn", 32'(pmod_rstn), 32'd1);
        bt_rst_req = 1'b1; src_rx = 3'b110;
        tick();
        bt_rst_req = 1'b0;
        chk("repulse_rstn", 32'(pmod_rstn), 32'd0);
        chk("repulse_rxd", 32'(pmod_rxd), 32'd1);
        repeat (5) begin
            tick();
            chk("pulse_rstn", 32'(pmod_rstn), 32'd0);
            chk("pulse_rxd", 32'(pmod_rxd), 32'd1);
        end
        bt_rst_req = 1'b1;
        tick();
        bt_rst_req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("restart_rstn_%0d", k), 32'(pmod_rstn), 32'(k == 8));
            chk($sformatf("restart_rxd_%0d", k), 32'(pmod_rxd), 32'(k != 8));
        end

        // Pending request retargeted to a third source takes the latest select.
        sel = 2'd1;
        tick();
        tick();
        sel = 2'd2;
        tick();
        chk("retarget_pending", 32'(switch_pending), 32'd1);
        chk("retarget_active_hold", 32'(active_sel), 32'd0);
        src_rx = 3'b111;
        for (int t = 0; t < 100 && active_sel == 2'd0; t++) tick();
        chk("retarget_active", 32'(active_sel), 32'd2);

        // Select returns to the active source: cancel without commit.
        src_rx = 3'b011; sel = 2'd0;
        tick();
        tick();
        chk("cancel_pending", 32'(switch_pending), 32'd1);
        sel = 2'd2;
        tick();
        chk("cancel_pending_clear", 32'(switch_pending), 32'd0);
        repeat (60) tick();
        chk("cancel_active", 32'(active_sel), 32'd2);
        src_rx = 3'b111;

`ifdef PMOD_BLE_BREAK_DET_EN
        pmod_txd = 1'b0;
        tick();
        tick();
        for (int j = 1; j <= 80; j++) begin
            tick();
            if (j == 79) chk("break_79", 32'(brk), 32'd0);
            if (j == 80) chk("break_80", 32'(brk), 32'd1);
        end
        pmod_txd = 1'b1;
        tick();
        tick();
        chk("break_held", 32'(brk), 32'd1);
        tick();
        chk("break_clear", 32'(brk), 32'd0);
`endif

        // Asynchronous reset mid-traffic, then a full-length pulse again.
        pmod_txd = 1'b0;
        repeat (3) tick();
        chk("pre_reset_sink", 32'(sink_tx), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_sink", 32'(sink_tx), 32'h7);
        chk("async_active", 32'(active_sel), 32'd0);
        chk("async_rstn", 32'(pmod_rstn), 32'd0);
        chk("async_rxd", 32'(pmod_rxd), 32'd1);
        pmod_txd = 1'b1; src_rx = 3'b111; sel = 2'd0;
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("repower_rstn_%0d", k), 32'(pmod_rstn), 32'(k == 8));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
